// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states, idle line level and bit-timing helper.
// Used by both uart_tx and uart_rx so the two ends of a link agree on framing.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam logic UART_IDLE_LEVEL = 1'b1;

    function automatic int unsigned cycles_per_bit(input int unsigned clk_hz,
                                                   input int unsigned bit_rate);
        return clk_hz / bit_rate;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CYCLES_PER_BIT-1 and flags the last cycle of each bit.
// Holding clear keeps the count at zero so a new bit always starts on a full period.
module uart_baud_cnt #(
    parameter int unsigned CYCLES_PER_BIT = 10
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    output logic bit_end
);

    localparam int unsigned CW = (CYCLES_PER_BIT > 2) ? $clog2(CYCLES_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CYCLES_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign bit_end = (cnt_q == LAST);

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || bit_end) begin
            cnt_d = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments only.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional even parity, stop bit(s).
// Define UART_TX_PARITY_EN to insert the parity bit; it must match uart_rx on the same link.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 50_000_000,
    parameter int unsigned BIT_RATE     = 9600,
    parameter int unsigned PAYLOAD_BITS = 8,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    uart_tx_en,
    input  logic [PAYLOAD_BITS-1:0] uart_tx_data,
    output logic                    uart_tx_busy,
    output logic                    uart_tx_done,
    output logic                    uart_txd
);

    localparam int unsigned CYCLES_PER_BIT = cycles_per_bit(CLK_HZ, BIT_RATE);
    localparam int unsigned BW = $clog2(PAYLOAD_BITS);
    localparam logic [BW-1:0] LAST_BIT = BW'(PAYLOAD_BITS - 1);
    localparam logic LAST_STOP = 1'(STOP_BITS - 1);

    uart_state_e             state_q, state_d;
    logic [PAYLOAD_BITS-1:0] shreg_q, shreg_d;
    logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
    logic                    stop_cnt_q, stop_cnt_d;
    logic                    txd_q, txd_d;
    logic                    done;
    logic                    bit_end;
`ifdef UART_TX_PARITY_EN
    logic                    parity_q, parity_d;
`endif

    // The counter is parked at zero while idle; thereafter it wraps exactly on each state change.
    uart_baud_cnt #(
        .CYCLES_PER_BIT(CYCLES_PER_BIT)
    ) u_baud_cnt (
        .clk    (clk),
        .resetn (resetn),
        .clear  (state_q == IDLE),
        .bit_end(bit_end)
    );

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        done       = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif

        case (state_q)
            IDLE: begin
                if (uart_tx_en) begin
                    shreg_d = uart_tx_data;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^uart_tx_data;
`endif
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d  = '0;
                        stop_cnt_d = 1'b0;
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    if (stop_cnt_q == LAST_STOP) begin
                        state_d = IDLE;
                        done    = 1'b1;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // The line level is decoded from the next state so uart_txd comes straight off a flop.
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  txd_d = parity_d;
`endif
            default: txd_d = UART_IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            txd_q      <= UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            txd_q      <= txd_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign uart_txd     = txd_q;
    assign uart_tx_busy = (state_q != IDLE);
    assign uart_tx_done = done;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 10 cycles/bit, 8N1 (8E1 when UART_TX_PARITY_EN is defined).
module tb_uart_tx;

    localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int NBITS = 1 + 8 + P + 1;
    localparam int FRAME = NBITS * CPB;

    logic       clk = 1'b0;
    logic       resetn;
    logic       uart_tx_en;
    logic [7:0] uart_tx_data;
    logic       uart_tx_busy;
    logic       uart_tx_done;
    logic       uart_txd;

    int total = 0;
    int bad   = 0;

    uart_tx #(
        .CLK_HZ      (1000),
        .BIT_RATE    (100),
        .PAYLOAD_BITS(8),
        .STOP_BITS   (1)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .uart_tx_en  (uart_tx_en),
        .uart_tx_data(uart_tx_data),
        .uart_tx_busy(uart_tx_busy),
        .uart_tx_done(uart_tx_done),
        .uart_txd    (uart_txd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " txd"}, {31'd0, uart_txd}, 32'd1);
        check({tag, " busy"}, {31'd0, uart_tx_busy}, 32'd0);
        check({tag, " done"}, {31'd0, uart_tx_done}, 32'd0);
    endtask

    // Called at the negedge of cycle 1 after the accepting edge; returns at the done cycle.
    // A positive inject pulses uart_tx_en with 0x3C at that cycle of the frame.
    task automatic expect_frame(input logic [7:0] d, input string tag, input int inject);
        logic exp_bits [NBITS];
        exp_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) exp_bits[1 + i] = d[i];
        if (P == 1) exp_bits[9] = ^d;
        exp_bits[NBITS - 1] = 1'b1;
        for (int n = 1; n <= FRAME; n++) begin
            if (n > 1) @(negedge clk);
            check($sformatf("%s txd c%0d", tag, n), {31'd0, uart_txd}, {31'd0, exp_bits[(n - 1) / CPB]});
            check($sformatf("%s busy c%0d", tag, n), {31'd0, uart_tx_busy}, 32'd1);
            check($sformatf("%s done c%0d", tag, n), {31'd0, uart_tx_done}, {31'd0, n == FRAME});
            if (inject > 0 && n == inject) begin
                uart_tx_en   = 1'b1;
                uart_tx_data = 8'h3C;
            end
            if (inject > 0 && n == inject + 1) uart_tx_en = 1'b0;
        end
    endtask

    task automatic send(input logic [7:0] d, input string tag);
        uart_tx_en   = 1'b1;
        uart_tx_data = d;
        @(negedge clk);
        uart_tx_en   = 1'b0;
        uart_tx_data = ~d;
        expect_frame(d, tag, -1);
        @(negedge clk);
        check_idle({tag, " after"});
    endtask

    initial begin
        resetn       = 1'b0;
        uart_tx_en   = 1'b0;
        uart_tx_data = 8'h00;
        repeat (2) @(negedge clk);
        check_idle("reset");
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        check_idle("idle");

        send(8'hA5, "a5");

        // Held request: two frames with exactly one idle cycle between them.
        uart_tx_en   = 1'b1;
        uart_tx_data = 8'h00;
        @(negedge clk);
        uart_tx_data = 8'hFF;
        expect_frame(8'h00, "b2b0", -1);
        @(negedge clk);
        check_idle("gap");
        @(negedge clk);
        uart_tx_en = 1'b0;
        expect_frame(8'hFF, "b2b1", -1);
        @(negedge clk);
        check_idle("b2b after");

        // Request while busy is dropped, not queued.
        uart_tx_en   = 1'b1;
        uart_tx_data = 8'h81;
        @(negedge clk);
        uart_tx_en = 1'b0;
        expect_frame(8'h81, "ignore", 40);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check_idle($sformatf("noq c%0d", i));
        end

        // Asynchronous reset in the middle of a frame.
        uart_tx_en   = 1'b1;
        uart_tx_data = 8'h55;
        @(negedge clk);
        uart_tx_en = 1'b0;
        repeat (34) @(negedge clk);
        check("mid busy", {31'd0, uart_tx_busy}, 32'd1);
        resetn = 1'b0;
        #1;
        check_idle("abort");
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check_idle("post rst");
        send(8'h12, "12");

        send(8'hA4, "a4");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
